reg_writeback_unit: RTL and testbench

REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

---
 rtl/lc3_pkg.sv | 34 +++
 rtl/wb_fifo.sv | 95 +++++++++
 rtl/reg_writeback_unit.sv | 145 ++++++++++++++
 tb/tb_reg_writeback_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: destination-select encoding, condition-code layout
// and the queued writeback entry format.
package lc3_pkg;

    typedef enum logic [1:0] {
        DR_NONE = 2'd0,
        DR_IR   = 2'd1,
        DR_R7   = 2'd2
    } dr_sel_e;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    localparam logic [2:0] NZP_RESET = 3'b010;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  dr;
        logic        ld;
        logic        set_cc;
    } wb_entry_t;

    // Exactly one flag is set for any 16-bit value.
    function automatic logic [2:0] calc_nzp(input logic [15:0] value);
        logic [2:0] flags;
        flags        = '0;
        flags[NZP_N] = value[15];
        flags[NZP_Z] = (value == 16'h0000);
        flags[NZP_P] = !value[15] && (value != 16'h0000);
        return flags;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of pending register writes; publishes per-slot valid,
// write-enable and destination so the parent can flag read hazards.
module wb_fifo
    import lc3_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 2) ? 2 : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  wb_entry_t          wdata_i,
    output wb_entry_t          rdata_o,
    output logic [CW-1:0]      count_o,
    output logic [DEPTH-1:0]   valid_o,
    output logic [DEPTH-1:0]   ld_o,
    output logic [3*DEPTH-1:0] dest_o
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_i) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = ptr_inc(rd_ptr_q);
            end
            if (push_i) begin
                mem_d[wr_ptr_q]   = wdata_i;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = ptr_inc(wr_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        ld_o   = '0;
        dest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_o[i]         = mem_q[i].ld;
            dest_o[3*i +: 3] = mem_q[i].dr;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback path: queues datapath results, drains one per cycle into a
// registered register-file write port, and maintains NZP condition codes and BEN.
module reg_writeback_unit
    import lc3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [15:0] wb_data,
    input  logic [15:0] wb_ir,
    input  logic [1:0]  wb_dr_sel,
    input  logic        wb_set_cc,
    input  logic        flush,
    output logic [15:0] data_in,
    output logic [2:0]  DR_reg,
    output logic        ld_reg,
    input  logic [2:0]  SR1_reg,
    input  logic [2:0]  SR2_reg,
    output logic        sr1_busy,
    output logic        sr2_busy,
    input  logic        ben_req,
    input  logic [2:0]  ir_nzp,
    output logic        ben,
    output logic [2:0]  nzp
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_ld;
    logic [3*DEPTH-1:0] entry_dest;
    logic             push;
    logic             pop;
    logic             unused_ir;

    logic        ld_q, ld_d;
    logic [2:0]  dr_q, dr_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        ben_q, ben_d;

    // The register file never stalls, so any queued entry drains every cycle;
    // flush overrides both directions.
    assign wb_ready = !reset && (count != FULL_COUNT);
    assign push     = wb_valid && wb_ready && !flush;
    assign pop      = (count != '0) && !flush;

    assign unused_ir = ^{wb_ir[15:12], wb_ir[8:0]};

    always_comb begin
        push_entry        = '0;
        push_entry.data   = wb_data;
        push_entry.set_cc = wb_set_cc;
        case (dr_sel_e'(wb_dr_sel))
            DR_IR: begin
                push_entry.dr = wb_ir[11:9];
                push_entry.ld = 1'b1;
            end
            DR_R7: begin
                push_entry.dr = 3'd7;
                push_entry.ld = 1'b1;
            end
            default: ;
        endcase
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (count),
        .valid_o (entry_valid),
        .ld_o    (entry_ld),
        .dest_o  (entry_dest)
    );

    // BEN samples the condition codes as they stood before this edge.
    always_comb begin
        ld_d   = 1'b0;
        dr_d   = dr_q;
        data_d = data_q;
        nzp_d  = nzp_q;
        ben_d  = ben_q;
        if (pop) begin
            ld_d   = head_entry.ld;
            dr_d   = head_entry.dr;
            data_d = head_entry.data;
            if (head_entry.set_cc) begin
                nzp_d = calc_nzp(head_entry.data);
            end
        end
        if (ben_req && !flush) begin
            ben_d = |(ir_nzp & nzp_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_q   <= 1'b0;
            dr_q   <= 3'd0;
            data_q <= 16'h0000;
            nzp_q  <= NZP_RESET;
            ben_q  <= 1'b0;
        end else begin
            ld_q   <= ld_d;
            dr_q   <= dr_d;
            data_q <= data_d;
            nzp_q  <= nzp_d;
            ben_q  <= ben_d;
        end
    end

    always_comb begin
        sr1_busy = ld_q && (dr_q == SR1_reg);
        sr2_busy = ld_q && (dr_q == SR2_reg);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_ld[i] && (entry_dest[3*i +: 3] == SR1_reg)) begin
                sr1_busy = 1'b1;
            end
            if (entry_valid[i] && entry_ld[i] && (entry_dest[3*i +: 3] == SR2_reg)) begin
                sr2_busy = 1'b1;
            end
        end
    end

    assign ld_reg  = ld_q;
    assign DR_reg  = dr_q;
    assign data_in = data_q;
    assign nzp     = nzp_q;
    assign ben     = ben_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: expected register writes go into a
// scoreboard queue that a negedge monitor drains whenever ld_reg is high.
module tb_reg_writeback_unit;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_IR   = 2'd1;
    localparam logic [1:0] SEL_R7   = 2'd2;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [15:0] wb_ir;
    logic [1:0]  wb_dr_sel;
    logic        wb_set_cc;
    logic        flush;
    logic [15:0] data_in;
    logic [2:0]  DR_reg;
    logic        ld_reg;
    logic [2:0]  SR1_reg;
    logic [2:0]  SR2_reg;
    logic        sr1_busy;
    logic        sr2_busy;
    logic        ben_req;
    logic [2:0]  ir_nzp;
    logic        ben;
    logic [2:0]  nzp;

    int checks = 0;
    int errors = 0;

    // Each entry is {DR, data} of a register write the DUT must produce.
    logic [18:0] expQ [$];

    reg_writeback_unit #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_ir     (wb_ir),
        .wb_dr_sel (wb_dr_sel),
        .wb_set_cc (wb_set_cc),
        .flush     (flush),
        .data_in   (data_in),
        .DR_reg    (DR_reg),
        .ld_reg    (ld_reg),
        .SR1_reg   (SR1_reg),
        .SR2_reg   (SR2_reg),
        .sr1_busy  (sr1_busy),
        .sr2_busy  (sr2_busy),
        .ben_req   (ben_req),
        .ir_nzp    (ir_nzp),
        .ben       (ben),
        .nzp       (nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                 input logic [15:0] ir, input logic [1:0] sel,
                                 input logic setCc, input logic expectWrite,
                                 input logic [2:0] expDr);
        wb_valid  = valid;
        wb_data   = data;
        wb_ir     = ir;
        wb_dr_sel = sel;
        wb_set_cc = setCc;
        if (valid && expectWrite) begin
            expQ.push_back({expDr, data});
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0000, 16'h0000, SEL_NONE, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && ld_reg) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got DR=%0d data=%h expected none at %0t",
                         DR_reg, data_in, $time);
            end else begin
                logic [18:0] exp;
                exp = expQ.pop_front();
                checkOutput("write_dr", {13'd0, DR_reg}, {13'd0, exp[18:16]});
                checkOutput("write_data", data_in, exp[15:0]);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        ben_req = 1'b0;
        ir_nzp  = 3'b000;
        SR1_reg = 3'd0;
        SR2_reg = 3'd0;
        idle();
        #2;
        checkOutput("rst_ld", {15'd0, ld_reg}, 16'd0);
        checkOutput("rst_dr", {13'd0, DR_reg}, 16'd0);
        checkOutput("rst_data", data_in, 16'h0000);
        checkOutput("rst_nzp", {13'd0, nzp}, 16'h0002);
        checkOutput("rst_ben", {15'd0, ben}, 16'd0);
        checkOutput("rst_ready", {15'd0, wb_ready}, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("ready_after_rst", {15'd0, wb_ready}, 16'd1);

        // Single negative result to R3 with CC update.
        applyStimulus(1'b1, 16'h8001, 16'h0600, SEL_IR, 1'b1, 1'b1, 3'd3);
        tick();
        idle();
        checkOutput("lat_not_early", {15'd0, ld_reg}, 16'd0);
        tick();
        checkOutput("lat_ld", {15'd0, ld_reg}, 16'd1);
        checkOutput("single_nzp", {13'd0, nzp}, 16'h0004);
        tick();
        checkOutput("single_ld_off", {15'd0, ld_reg}, 16'd0);
        checkOutput("single_nzp_hold", {13'd0, nzp}, 16'h0004);

        // Three back-to-back results.
        applyStimulus(1'b1, 16'h0011, 16'h0200, SEL_IR, 1'b0, 1'b1, 3'd1);
        checkOutput("b2b_ready0", {15'd0, wb_ready}, 16'd1);
        tick();
        applyStimulus(1'b1, 16'h0022, 16'h0000, SEL_R7, 1'b0, 1'b1, 3'd7);
        checkOutput("b2b_ready1", {15'd0, wb_ready}, 16'd1);
        tick();
        checkOutput("b2b_ld1", {15'd0, ld_reg}, 16'd1);
        applyStimulus(1'b1, 16'h0033, 16'h0A00, SEL_IR, 1'b0, 1'b1, 3'd5);
        checkOutput("b2b_ready2", {15'd0, wb_ready}, 16'd1);
        tick();
        checkOutput("b2b_ld2", {15'd0, ld_reg}, 16'd1);
        idle();
        tick();
        checkOutput("b2b_ld3", {15'd0, ld_reg}, 16'd1);
        tick();
        checkOutput("b2b_ld_off", {15'd0, ld_reg}, 16'd0);
        checkOutput("b2b_nzp", {13'd0, nzp}, 16'h0004);

        // Hazard tracking on R7.
        SR1_reg = 3'd7;
        SR2_reg = 3'd3;
        applyStimulus(1'b1, 16'h3000, 16'h0000, SEL_R7, 1'b0, 1'b1, 3'd7);
        checkOutput("busy_before", {15'd0, sr1_busy}, 16'd0);
        tick();
        idle();
        checkOutput("busy_queued", {15'd0, sr1_busy}, 16'd1);
        checkOutput("busy_sr2_clear", {15'd0, sr2_busy}, 16'd0);
        tick();
        checkOutput("busy_ld", {15'd0, sr1_busy}, 16'd1);
        checkOutput("busy_ld_dr", {13'd0, DR_reg}, 16'd7);
        tick();
        checkOutput("busy_after", {15'd0, sr1_busy}, 16'd0);

        // NONE destination: no write, CC still updated (zero -> 010).
        applyStimulus(1'b1, 16'h0000, 16'h0000, SEL_NONE, 1'b1, 1'b0, 3'd0);
        tick();
        idle();
        tick();
        checkOutput("none_no_ld", {15'd0, ld_reg}, 16'd0);
        checkOutput("none_nzp", {13'd0, nzp}, 16'h0002);

        // BEN uses old NZP while the same edge updates NZP.
        applyStimulus(1'b1, 16'h0005, 16'h0400, SEL_IR, 1'b1, 1'b1, 3'd2);
        tick();
        idle();
        ben_req = 1'b1;
        ir_nzp  = 3'b010;
        tick();
        ben_req = 1'b0;
        checkOutput("ben_old_nzp", {15'd0, ben}, 16'd1);
        checkOutput("ben_new_nzp", {13'd0, nzp}, 16'h0001);
        tick();
        checkOutput("ben_hold", {15'd0, ben}, 16'd1);
        ben_req = 1'b1;
        ir_nzp  = 3'b100;
        tick();
        ben_req = 1'b0;
        checkOutput("ben_clear", {15'd0, ben}, 16'd0);

        // Flush with one write in the output stage and one queued.
        applyStimulus(1'b1, 16'h1234, 16'h0800, SEL_IR, 1'b0, 1'b1, 3'd4);
        tick();
        applyStimulus(1'b1, 16'h8000, 16'h0C00, SEL_IR, 1'b1, 1'b0, 3'd0);
        tick();
        checkOutput("flush_pre_ld", {15'd0, ld_reg}, 16'd1);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h7777, 16'h0000, SEL_R7, 1'b1, 1'b0, 3'd0);
        tick();
        flush = 1'b0;
        idle();
        checkOutput("flush_ld", {15'd0, ld_reg}, 16'd0);
        checkOutput("flush_nzp", {13'd0, nzp}, 16'h0001);
        tick();
        checkOutput("flush_no_write1", {15'd0, ld_reg}, 16'd0);
        tick();
        checkOutput("flush_no_write2", {15'd0, ld_reg}, 16'd0);
        checkOutput("flush_nzp_hold", {13'd0, nzp}, 16'h0001);
        checkOutput("flush_ben_hold", {15'd0, ben}, 16'd0);

        // Asynchronous reset while a write is presented and another is queued.
        applyStimulus(1'b1, 16'hC000, 16'h0200, SEL_IR, 1'b1, 1'b1, 3'd1);
        tick();
        applyStimulus(1'b1, 16'h5555, 16'h0A00, SEL_IR, 1'b1, 1'b0, 3'd0);
        tick();
        idle();
        checkOutput("arst_pre_ld", {15'd0, ld_reg}, 16'd1);
        checkOutput("arst_pre_nzp", {13'd0, nzp}, 16'h0004);
        #6;
        reset = 1'b1;
        #1;
        checkOutput("arst_ld", {15'd0, ld_reg}, 16'd0);
        checkOutput("arst_nzp", {13'd0, nzp}, 16'h0002);
        checkOutput("arst_dr", {13'd0, DR_reg}, 16'd0);
        checkOutput("arst_data", data_in, 16'h0000);
        checkOutput("arst_ready", {15'd0, wb_ready}, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_ld1", {15'd0, ld_reg}, 16'd0);
        tick();
        checkOutput("post_rst_ld2", {15'd0, ld_reg}, 16'd0);
        checkOutput("post_rst_ready", {15'd0, wb_ready}, 16'd1);
        tick();
        tick();

        checkOutput("scoreboard_drained", 16'(expQ.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
